uart_rx: RTL and testbench

Memory-mapped UART receiver, the receive-side counterpart of the `uartTx` peripheral on the same picorv32-style native memory bus. It samples the asynchronous `serialIn` line and deframes 8N1 characters, LSB first. Received bytes go into a small FIFO that the CPU drains through data and status registers. It sits beside `uartTx` behind the top-level address decoder, which drives `enable`.

---
 rtl/uart_rx.sv | 147 ++++++++++++++
 tb/tb_uart_rx.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: memory-mapped 8N1 UART receiver with receive FIFO and sticky error flags.
// Define UART_RX_PARITY_EN to expect one even-parity bit between data and stop.
module uart_rx #(
    parameter int BAUD_DIV   = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    input  logic        serialIn
);
    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] FULL_CNT = CW'(BAUD_DIV);

    typedef enum logic [2:0] {HUNT, IDLE, START, DATA, STOP
`ifdef UART_RX_PARITY_EN
        , PARITY
`endif
    } state_t;

`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    logic          s1, rxs;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    sh, sh_n;
    logic [2:0]    bitn, bit_n;
    logic          bad, bad_n, push_q, push_n, ferr_set, perr_set, tick;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wp, rp;
    logic          empty, full, acc, rd, rd_data, rd_stat, pop, do_push, ovr_set;
    logic          ovr, ferr, perr;
    logic [31:0]   status;
    logic          unused_ok;

    assign unused_ok = ^{mem_instr, mem_wdata, mem_addr[31:3], mem_addr[1:0]};

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) {s1, rxs} <= 2'b11;
        else         {s1, rxs} <= {serialIn, s1};

    assign tick = cnt == CW'(1);

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state  <= HUNT;
            cnt    <= '0;
            sh     <= '0;
            bitn   <= '0;
            bad    <= 1'b0;
            push_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            sh     <= sh_n;
            bitn   <= bit_n;
            bad    <= bad_n;
            push_q <= push_n;
        end

    // Every bit decision is taken at counter expiry, i.e. mid-bit
    always_comb begin
        state_n  = state;
        cnt_n    = tick ? FULL_CNT : cnt - 1'b1;
        sh_n     = sh;
        bit_n    = bitn;
        bad_n    = bad;
        push_n   = 1'b0;
        ferr_set = 1'b0;
        perr_set = 1'b0;
        case (state)
            HUNT:  state_n = rxs ? IDLE : HUNT;
            IDLE:  if (!rxs) begin
                state_n = START;
                cnt_n   = HALF;
                bit_n   = '0;
                bad_n   = 1'b0;
            end
            START: if (tick) state_n = rxs ? IDLE : DATA;
            DATA:  if (tick) begin
                sh_n    = {rxs, sh[7:1]};
                bit_n   = bitn + 1'b1;
                state_n = (bitn == 3'd7) ? AFTER_DATA : DATA;
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick) begin
                perr_set = rxs != ^sh;
                bad_n    = rxs != ^sh;
                state_n  = STOP;
            end
`endif
            STOP:  if (tick) begin
                push_n   = rxs & ~bad;
                ferr_set = ~rxs;
                state_n  = rxs ? IDLE : HUNT;
            end
            default: state_n = HUNT;
        endcase
    end

    assign empty   = wp == rp;
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign acc     = enable & mem_valid & ~mem_ready;
    assign rd      = acc & ~|mem_wstrb;
    assign rd_data = rd & ~mem_addr[2];
    assign rd_stat = rd & mem_addr[2];
    assign pop     = rd_data & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte
    assign do_push = push_q & (~full | pop);
    assign ovr_set = push_q & full & ~pop;
    assign status  = {27'b0, perr, ferr, ovr, full, ~empty};

    always_ff @(posedge clk)
        if (do_push) fifo_mem[wp[AW-1:0]] <= sh;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            wp        <= '0;
            rp        <= '0;
            ovr       <= 1'b0;
            ferr      <= 1'b0;
            perr      <= 1'b0;
        end else begin
            mem_ready <= acc;
            mem_rdata <= pop ? {24'b0, fifo_mem[rp[AW-1:0]]} : rd_stat ? status : '0;
            wp        <= wp + (AW+1)'(do_push);
            rp        <= rp + (AW+1)'(pop);
            ovr       <= ovr_set | (ovr & ~rd_stat);
            ferr      <= ferr_set | (ferr & ~rd_stat);
            perr      <= perr_set | (perr & ~rd_stat);
        end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed table-driven bench for uart_rx at BAUD_DIV=16, FIFO_DEPTH=8.
module tb_uart_rx;
    localparam int BD = 16;
    localparam logic [31:0] A_DATA = 32'hffff0048;
    localparam logic [31:0] A_STAT = 32'hffff004c;

    logic        clk = 1'b0, resetn = 1'b0, enable = 1'b0, mem_valid = 1'b0, mem_instr = 1'b0;
    logic        serialIn = 1'b1;
    logic [3:0]  mem_wstrb = '0;
    logic [31:0] mem_wdata = '0, mem_addr = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        logic [7:0]  din;
        logic        stop_bit;
        logic        par_bad;
        logic [31:0] st1;
        logic [31:0] dat;
        logic [31:0] st2;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    uart_rx #(.BAUD_DIV(BD), .FIFO_DEPTH(8)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .mem_valid(mem_valid),
        .mem_instr(mem_instr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .serialIn(serialIn)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus(input logic [31:0] addr, input logic [3:0] wstrb, input string name,
                       output logic [31:0] rdv);
        int n = 0;
        enable = 1'b1; mem_valid = 1'b1; mem_addr = addr; mem_wstrb = wstrb; mem_wdata = 32'hdeadbeef;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_ready && n < 8);
        enable = 1'b0; mem_valid = 1'b0; mem_wstrb = '0;
        check({name, " ready"}, {31'b0, mem_ready}, 32'h1);
        rdv = mem_rdata;
        @(negedge clk);
        check({name, " ready pulse"}, {31'b0, mem_ready}, 32'h0);
        check({name, " rdata idle"}, mem_rdata, 32'h0);
    endtask

    task automatic rd(input logic [31:0] addr, input string name, input logic [31:0] exp);
        logic [31:0] v;
        bus(addr, 4'h0, name, v);
        check(name, v, exp);
    endtask

    task automatic bit_time(input logic v);
        serialIn = v;
        repeat (BD) @(negedge clk);
    endtask

    // Drives start, data, optional parity and the stop level; the line is left at the stop level
    task automatic frame(input logic [7:0] b, input logic stop, input logic par_bad);
        logic p;
        p = ^b ^ par_bad;
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
        bit_time(p);
`endif
        bit_time(stop);
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input logic par_bad, input int idle);
        frame(b, stop, par_bad);
        serialIn = 1'b1;
        repeat (idle) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{8'hA5, 1'b1, 1'b0, 32'h1, 32'hA5, 32'h0});
        vecs.push_back('{8'h00, 1'b1, 1'b0, 32'h1, 32'h00, 32'h0});
        vecs.push_back('{8'hFF, 1'b1, 1'b0, 32'h1, 32'hFF, 32'h0});
        vecs.push_back('{8'h3C, 1'b0, 1'b0, 32'h8, 32'h00, 32'h0});
        vecs.push_back('{8'h5A, 1'b1, 1'b0, 32'h1, 32'h5A, 32'h0});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b1, 32'h10, 32'h00, 32'h0});
        vecs.push_back('{8'h07, 1'b1, 1'b0, 32'h1, 32'h07, 32'h0});
`endif

        repeat (3) @(negedge clk);
        check("reset ready", {31'b0, mem_ready}, 32'h0);
        check("reset rdata", mem_rdata, 32'h0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        rd(A_STAT, "reset status", 32'h0);
        rd(A_DATA, "empty data", 32'h0);

        foreach (vecs[i]) begin
            send(vecs[i].din, vecs[i].stop_bit, vecs[i].par_bad, 4);
            rd(A_STAT, $sformatf("v%0d status", i), vecs[i].st1);
            rd(A_DATA, $sformatf("v%0d data", i), vecs[i].dat);
            rd(A_STAT, $sformatf("v%0d status after", i), vecs[i].st2);
        end

        for (int i = 1; i <= 9; i++) send(8'(i), 1'b1, 1'b0, 0);
        repeat (4) @(negedge clk);
        rd(A_STAT, "overrun status", 32'h7);
        for (int i = 1; i <= 8; i++) rd(A_DATA, $sformatf("overrun data %0d", i), 32'(i));
        rd(A_STAT, "overrun status after", 32'h0);

        frame(8'h3C, 1'b0, 1'b0);
        repeat (30 * BD) @(negedge clk);
        rd(A_STAT, "held low ferr", 32'h8);
        repeat (30 * BD) @(negedge clk);
        rd(A_STAT, "held low quiet", 32'h0);
        serialIn = 1'b1;
        repeat (2 * BD) @(negedge clk);
        send(8'h42, 1'b1, 1'b0, 4);
        rd(A_STAT, "after low status", 32'h1);
        rd(A_DATA, "after low data", 32'h42);

        serialIn = 1'b0;
        repeat (4) @(negedge clk);
        serialIn = 1'b1;
        repeat (20 * BD) @(negedge clk);
        rd(A_STAT, "glitch status", 32'h0);
        rd(A_DATA, "glitch data", 32'h0);

        bit_time(1'b0);
        for (int i = 0; i < 3; i++) bit_time(i[0] ? 1'b0 : 1'b1);
        serialIn = 1'b0;
        repeat (BD / 2) @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset ready", {31'b0, mem_ready}, 32'h0);
        resetn = 1'b1;
        repeat (BD / 2) @(negedge clk);
        serialIn = 1'b1;
        repeat (2 * BD) @(negedge clk);
        send(8'h81, 1'b1, 1'b0, 4);
        rd(A_STAT, "midreset status", 32'h1);
        begin
            logic [31:0] v;
            bus(A_DATA, 4'hF, "write data", v);
            check("write rdata", v, 32'h0);
        end
        rd(A_STAT, "after write status", 32'h1);
        rd(A_DATA, "midreset data", 32'h81);
        rd(A_STAT, "midreset status after", 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
